// File: rtl/sap_pkg.sv
// ============================================================================
// Module : sap_pkg
// Brief  : Shared types and default widths for the bus RAM controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sap_pkg;

    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        PROG  = 2'd2
    } ram_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_ram_array.sv
// ============================================================================
// Module : bus_ram_array
// Brief  : DEPTH x DATA_W storage, one synchronous write port, one async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    // Contents are deliberately unreset; the controller's CLEAR sweep owns init.
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/bus_ram_ctrl.sv
// ============================================================================
// Module : bus_ram_ctrl
// Brief  : Bus-attached main memory with CLEAR sweep, RUN access and PROG loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_ram_ctrl
    import sap_pkg::*;
#(
    parameter int               DATA_W   = c_DEF_DATA_W,
    parameter int               ADDR_W   = c_DEF_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] prog_ptr,
    output logic              rw_err
);

    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    ram_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] r_prog_ptr;
    logic              r_rw_err;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_ptr  <= '0;
            r_prog_ptr <= '0;
            r_rw_err   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == c_LAST) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (ram_read && ram_write) begin
                        r_rw_err <= 1'b1;
                    end
                    if (prog_mode) begin
                        r_state    <= PROG;
                        r_prog_ptr <= '0;
                    end
                end
                PROG: begin
                    if (prog_valid) begin
                        r_prog_ptr <= r_prog_ptr + 1'b1;
                    end
                    if (!prog_mode) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Single write port shared by the sweep, the CPU and the loader.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = addr;
        w_wdata = bus;
        case (r_state)
            CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_ptr;
                w_wdata = INIT_VAL;
            end
            RUN: begin
                w_we = ram_write;
            end
            PROG: begin
                w_we    = prog_valid;
                w_waddr = r_prog_ptr;
                w_wdata = prog_data;
            end
            default: w_we = 1'b0;
        endcase
    end

    bus_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (addr),
        .rdata (w_rdata)
    );

    // Read is zero-latency so the consumer can latch on the same edge.
    assign w_drive = (r_state == RUN) && ram_read && !ram_write;
    assign bus     = w_drive ? w_rdata : {DATA_W{1'bz}};

    assign busy       = (r_state == CLEAR);
    assign prog_ready = (r_state == PROG);
    assign prog_ptr   = r_prog_ptr;
    assign rw_err     = r_rw_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_ram_ctrl.sv
// ============================================================================
// Module : tb_bus_ram_ctrl
// Brief  : Directed self-checking bench for bus_ram_ctrl (8-bit, 16 words).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bus_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ram_read;
    logic       ram_write;
    logic [3:0] addr;
    wire  [7:0] bus;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       busy;
    logic [3:0] prog_ptr;
    logic       rw_err;

    logic       tb_en;
    logic [7:0] tb_drv;

    int n_assert = 0;
    int n_fail   = 0;
    int n_cyc;

    always #5 clk = ~clk;

    // An undriven bus floats to 8'hFF, which no checked memory word holds.
    pullup (bus);
    assign bus = tb_en ? tb_drv : 8'hzz;

    bus_ram_ctrl #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .INIT_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .addr       (addr),
        .bus        (bus),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .busy       (busy),
        .prog_ptr   (prog_ptr),
        .rw_err     (rw_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
        ram_read  = 1'b1;
        ram_write = 1'b0;
        addr      = a;
        #1;
        chk(tag, {24'h0, bus}, {24'h0, exp});
        ram_read  = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        n_cyc = 0;
        while (busy && n_cyc < 40) begin
            tick();
            n_cyc++;
        end
        chk(tag, n_cyc, 16);
    endtask

    initial begin
        rst_n = 1'b0; ram_read = 1'b0; ram_write = 1'b0; addr = '0;
        prog_mode = 1'b0; prog_valid = 1'b0; prog_data = '0;
        tb_en = 1'b0; tb_drv = '0;
        repeat (3) tick();

        chk("rst_busy",  {31'h0, busy},       1);
        chk("rst_ready", {31'h0, prog_ready}, 0);
        chk("rst_ptr",   {28'h0, prog_ptr},   0);
        chk("rst_err",   {31'h0, rw_err},     0);
        chk("rst_bus",   {24'h0, bus},        32'hFF);

        rst_n = 1'b1;
        wait_clear("clear_cycles");
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "clear_word");

        // RUN write then read back
        ram_write = 1'b1; addr = 4'd3; tb_en = 1'b1; tb_drv = 8'hA5;
        tick();
        ram_write = 1'b0; tb_en = 1'b0;
        rd(4'd3, 8'hA5, "run_rd3");
        #1;
        chk("run_idle_z", {24'h0, bus}, 32'hFF);

        // Read and write together: write wins, RAM stays off the bus
        ram_read = 1'b1; ram_write = 1'b1; addr = 4'd5; tb_en = 1'b1; tb_drv = 8'h7E;
        #1;
        chk("rw_bus", {24'h0, bus}, 32'h7E);
        chk("rw_err_pre", {31'h0, rw_err}, 0);
        tick();
        ram_read = 1'b0; ram_write = 1'b0; tb_en = 1'b0;
        chk("rw_err_set", {31'h0, rw_err}, 1);
        rd(4'd5, 8'h7E, "rw_mem5");
        repeat (3) tick();
        chk("rw_err_sticky", {31'h0, rw_err}, 1);

        // PROG with gaps
        prog_mode = 1'b1;
        tick();
        chk("prog_ready", {31'h0, prog_ready}, 1);
        chk("prog_ptr0",  {28'h0, prog_ptr},   0);
        chk("prog_busy",  {31'h0, busy},       0);
        ram_read = 1'b1; addr = 4'd3;
        #1;
        chk("prog_bus_z", {24'h0, bus}, 32'hFF);
        ram_read = 1'b0;
        prog_valid = 1'b1; prog_data = 8'h11; tick();
        prog_valid = 1'b0; tick();
        prog_valid = 1'b1; prog_data = 8'h23; tick();
        prog_valid = 1'b0; tick(); tick();
        prog_valid = 1'b1; prog_data = 8'h30; tick();
        prog_valid = 1'b0;
        chk("prog_ptr3", {28'h0, prog_ptr}, 3);
        // CPU write must be ignored in PROG
        ram_write = 1'b1; addr = 4'd0; tb_en = 1'b1; tb_drv = 8'h55;
        tick();
        ram_write = 1'b0; tb_en = 1'b0;
        prog_mode = 1'b0;
        tick();
        chk("run_ready0", {31'h0, prog_ready}, 0);
        chk("run_ptr_hold", {28'h0, prog_ptr}, 3);
        rd(4'd0, 8'h11, "prog_mem0");
        rd(4'd1, 8'h23, "prog_mem1");
        rd(4'd2, 8'h30, "prog_mem2");
        rd(4'd3, 8'hA5, "prog_mem3");

        // 17 words wrap; last word rides the edge where prog_mode drops
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            prog_valid = 1'b1; prog_data = 8'(i);
            if (i == 16) prog_mode = 1'b0;
            tick();
        end
        prog_valid = 1'b0;
        chk("wrap_ptr", {28'h0, prog_ptr}, 1);
        chk("wrap_run", {31'h0, prog_ready}, 0);
        rd(4'd0,  8'h10, "wrap_mem0");
        rd(4'd5,  8'h05, "wrap_mem5");
        rd(4'd15, 8'h0F, "wrap_mem15");

        // Reset mid-PROG
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            prog_valid = 1'b1; prog_data = 8'hC0 + 8'(i);
            tick();
        end
        prog_valid = 1'b0;
        chk("mid_ptr4", {28'h0, prog_ptr}, 4);
        rst_n = 1'b0;
        #1;
        chk("async_busy",  {31'h0, busy},       1);
        chk("async_ptr",   {28'h0, prog_ptr},   0);
        chk("async_err",   {31'h0, rw_err},     0);
        chk("async_ready", {31'h0, prog_ready}, 0);
        prog_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_clear("reclear_cycles");
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "reclear_word");
        chk("reclear_ptr", {28'h0, prog_ptr}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
